// File: rtl/rnn_frame_driver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rnn_frame_driver_pkg : shared sizes, state encoding, width helper    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rnn_frame_driver_pkg;

   localparam int FIXED      = 32;
   localparam int INPUT_SIZE = 42;
   localparam int GAIN_SIZE  = 22;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   localparam int K_W = clog2(INPUT_SIZE);
   localparam int J_W = clog2(GAIN_SIZE + 1);

   typedef enum logic [2:0] {
      ST_LOAD  = 3'd0,
      ST_START = 3'd1,
      ST_GUARD = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rnn_result_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rnn_result_serializer : buffers vad + gains, streams 1+GAIN_SIZE words|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rnn_result_serializer
   import rnn_frame_driver_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       capture,
   input  logic                       capture_zero,
   input  logic [FIXED-1:0]           vad,
   input  logic [GAIN_SIZE*FIXED-1:0] gains,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [FIXED-1:0]           out_data,
   output logic                       out_last,
   output logic                       done
);

   logic [FIXED-1:0]           vad_q, vad_d;
   logic [GAIN_SIZE*FIXED-1:0] gains_q, gains_d;
   logic [J_W-1:0]             j_q, j_d;
   logic                       active_q, active_d;
   logic [FIXED-1:0]           gain_word [GAIN_SIZE];
   logic [J_W-1:0]             gain_idx;
   logic                       handshake;

   generate
      for (genvar g = 0; g < GAIN_SIZE; g++) begin : g_unpack
         assign gain_word[g] = gains_q[g*FIXED +: FIXED];
      end
   endgenerate

   always_comb begin
      vad_d     = vad_q;
      gains_d   = gains_q;
      j_d       = j_q;
      active_d  = active_q;
      handshake = active_q && out_ready;
      done      = handshake && (j_q == J_W'(GAIN_SIZE));
      gain_idx  = j_q - J_W'(1);

      if (capture) begin
         active_d = 1'b1;
         j_d      = '0;
         vad_d    = capture_zero ? '0 : vad;
         gains_d  = capture_zero ? '0 : gains;
      end else if (handshake) begin
         if (done) begin
            active_d = 1'b0;
            j_d      = '0;
         end else begin
            j_d = j_q + J_W'(1);
         end
      end

      // Word 0 is vad; words 1..GAIN_SIZE are gains[j-1].
      out_valid = active_q;
      out_data  = (j_q == '0) ? vad_q : gain_word[gain_idx];
      out_last  = active_q && (j_q == J_W'(GAIN_SIZE));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vad_q    <= '0;
         gains_q  <= '0;
         j_q      <= '0;
         active_q <= 1'b0;
      end else begin
         vad_q    <= vad_d;
         gains_q  <= gains_d;
         j_q      <= j_d;
         active_q <= active_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rnn_frame_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rnn_frame_driver : frame loader / start sequencer for the RNN core.  |
// | Optional watchdog enabled by `define RNN_TIMEOUT_EN. Rev 1.0         |
// +----------------------------------------------------------------------+
module rnn_frame_driver
   import rnn_frame_driver_pkg::*;
`ifdef RNN_TIMEOUT_EN
#(
   parameter int TIMEOUT_CYCLES = 65535
)
`endif
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [FIXED-1:0]            in_data,
   input  logic                        in_last,
   output logic [INPUT_SIZE*FIXED-1:0] rnn_feature,
   output logic                        rnn_start,
   input  logic                        rnn_valid,
   input  logic [FIXED-1:0]            rnn_vad,
   input  logic [GAIN_SIZE*FIXED-1:0]  rnn_gains,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [FIXED-1:0]            out_data,
   output logic                        out_last,
   output logic                        busy,
   output logic [15:0]                 frame_count,
`ifdef RNN_TIMEOUT_EN
   output logic                        err_timeout,
`endif
   output logic                        err_framing
);

   state_t                      state_q, state_d;
   logic [K_W-1:0]              k_q, k_d;
   logic [INPUT_SIZE*FIXED-1:0] feature_q, feature_d;
   logic [15:0]                 frame_count_q, frame_count_d;
   logic                        err_framing_q, err_framing_d;
   logic                        in_ready_q, in_ready_d;
   logic                        capture, capture_zero, drain_done, accept;
`ifdef RNN_TIMEOUT_EN
   logic [15:0]                 timer_q, timer_d;
   logic                        err_timeout_q, err_timeout_d;
`endif

   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      feature_d     = feature_q;
      frame_count_d = frame_count_q;
      err_framing_d = err_framing_q;
      capture       = 1'b0;
      capture_zero  = 1'b0;
      accept        = in_ready_q && in_valid;
`ifdef RNN_TIMEOUT_EN
      timer_d       = '0;
      err_timeout_d = err_timeout_q;
`endif

      unique case (state_q)
         ST_LOAD: begin
            if (accept) begin
               feature_d[k_q*FIXED +: FIXED] = in_data;
               // Word count decides the frame end; a missing last is only flagged.
               if (k_q == K_W'(INPUT_SIZE - 1)) begin
                  k_d     = '0;
                  state_d = ST_START;
                  if (!in_last) err_framing_d = 1'b1;
               end else if (in_last) begin
                  k_d           = '0;
                  err_framing_d = 1'b1;
               end else begin
                  k_d = k_q + K_W'(1);
               end
            end
         end
         ST_START: state_d = ST_GUARD;
         // The core's previous valid may still be high here, so it is not looked at.
         ST_GUARD: state_d = ST_WAIT;
         ST_WAIT: begin
`ifdef RNN_TIMEOUT_EN
            timer_d = timer_q + 16'd1;
`endif
            if (rnn_valid) begin
               capture       = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
               state_d       = ST_DRAIN;
            end
`ifdef RNN_TIMEOUT_EN
            else if (timer_q == 16'(TIMEOUT_CYCLES - 1)) begin
               capture       = 1'b1;
               capture_zero  = 1'b1;
               err_timeout_d = 1'b1;
               state_d       = ST_DRAIN;
            end
`endif
         end
         ST_DRAIN: begin
            if (drain_done) state_d = ST_LOAD;
         end
         default: state_d = ST_LOAD;
      endcase

      in_ready_d = (state_d == ST_LOAD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_LOAD;
         k_q           <= '0;
         feature_q     <= '0;
         frame_count_q <= '0;
         err_framing_q <= 1'b0;
         in_ready_q    <= 1'b0;
`ifdef RNN_TIMEOUT_EN
         timer_q       <= '0;
         err_timeout_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         feature_q     <= feature_d;
         frame_count_q <= frame_count_d;
         err_framing_q <= err_framing_d;
         in_ready_q    <= in_ready_d;
`ifdef RNN_TIMEOUT_EN
         timer_q       <= timer_d;
         err_timeout_q <= err_timeout_d;
`endif
      end
   end

   rnn_result_serializer u_serializer (
      .clk          (clk),
      .rst_n        (rst_n),
      .capture      (capture),
      .capture_zero (capture_zero),
      .vad          (rnn_vad),
      .gains        (rnn_gains),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .done         (drain_done)
   );

   assign in_ready    = in_ready_q;
   assign rnn_start   = (state_q == ST_START);
   assign rnn_feature = feature_q;
   assign busy        = (state_q != ST_LOAD) || (k_q != '0);
   assign frame_count = frame_count_q;
   assign err_framing = err_framing_q;
`ifdef RNN_TIMEOUT_EN
   assign err_timeout = err_timeout_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rnn_frame_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rnn_frame_driver : frame-level directed bench for rnn_frame_driver |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rnn_frame_driver;
   import rnn_frame_driver_pkg::*;

   localparam int NW = INPUT_SIZE;
   localparam int NG = GAIN_SIZE;
   localparam int NO = GAIN_SIZE + 1;

   logic                   clk, rst_n;
   logic                   in_valid, in_ready, in_last;
   logic [FIXED-1:0]       in_data;
   logic [NW*FIXED-1:0]    rnn_feature;
   logic                   rnn_start, rnn_valid;
   logic [FIXED-1:0]       rnn_vad;
   logic [NG*FIXED-1:0]    rnn_gains;
   logic                   out_valid, out_ready, out_last;
   logic [FIXED-1:0]       out_data;
   logic                   busy, err_framing;
   logic [15:0]            frame_count;
`ifdef RNN_TIMEOUT_EN
   logic                   err_timeout;
`endif

   int checks = 0;
   int errors = 0;

`ifdef RNN_TIMEOUT_EN
   rnn_frame_driver #(.TIMEOUT_CYCLES(100)) dut (
`else
   rnn_frame_driver dut (
`endif
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .rnn_feature(rnn_feature), .rnn_start(rnn_start), .rnn_valid(rnn_valid),
      .rnn_vad(rnn_vad), .rnn_gains(rnn_gains),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .frame_count(frame_count),
`ifdef RNN_TIMEOUT_EN
      .err_timeout(err_timeout),
`endif
      .err_framing(err_framing)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] feat_base;
      int          last_idx;   // -1: in_last never asserted
      logic [31:0] vad;
      logic [31:0] gain_base;
      int          lat;
      bit          stale;
      bit          bp;
      bit          no_core;
      int          exp_starts;
      bit          exp_err;
      logic [15:0] exp_fc;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Drives one frame, models the core and the sink; all activity on negedges.
   task automatic run_frame(input vec_t v);
      int nwords, i, j, starts, lat_cnt, drop_cnt, last_cyc, vset_cyc, tail;
      bit seen_ov, stall, done;
      logic [31:0] held_data, exp_w;
      logic        held_last;
      nwords = (v.last_idx >= 0) ? v.last_idx + 1 : NW;
      i = 0; j = 0; starts = 0; lat_cnt = 0; drop_cnt = 0;
      last_cyc = -10; vset_cyc = -10; tail = 0;
      seen_ov = 0; stall = 0; done = 0; held_data = '0; held_last = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 800 && !done; cyc++) begin
         @(negedge clk);
         if (stall) begin
            chk("stall_data", out_data, held_data);
            chk("stall_last", out_last, held_last);
            stall = 0;
         end
         if (drop_cnt > 0) begin
            drop_cnt--;
            if (drop_cnt == 0) rnn_valid = 1'b0;
         end
         if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0 && !v.no_core) begin
               rnn_valid = 1'b1;
               rnn_vad   = v.vad;
               for (int g = 0; g < NG; g++) rnn_gains[g*32 +: 32] = v.gain_base + 32'(g);
               vset_cyc = cyc;
            end
         end
         if (rnn_start) begin
            starts++;
            chk("start_latency", cyc, last_cyc + 1);
            chk("feature_w5", rnn_feature[5*32 +: 32], v.feat_base + 32'd5);
            chk("feature_w41", rnn_feature[41*32 +: 32], v.feat_base + 32'd41);
            if (v.stale) drop_cnt = 2;
            else rnn_valid = 1'b0;
            lat_cnt = v.lat;
         end
         if (v.bp) out_ready = ~out_ready;
         else out_ready = 1'b1;
         if (out_valid) begin
            chk("in_ready_drain", in_ready, 1'b0);
            if (!seen_ov) begin
               seen_ov = 1;
               if (!v.no_core) chk("valid_latency", cyc, vset_cyc + 1);
            end
            if (out_ready) begin
               exp_w = v.no_core ? 32'h0 : ((j == 0) ? v.vad : v.gain_base + 32'(j - 1));
               chk("out_data", out_data, exp_w);
               chk("out_last", out_last, (j == NG));
               j++;
            end else begin
               stall = 1; held_data = out_data; held_last = out_last;
            end
         end
         if (i < nwords && in_ready) begin
            in_valid = 1'b1;
            in_data  = v.feat_base + 32'(i);
            in_last  = (i == v.last_idx);
            if (i == nwords - 1) last_cyc = cyc;
            i++;
         end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
         end
         if (i == nwords && (v.exp_starts == 0 || j >= NO)) tail++;
         if (tail == 20 || (j >= NO && tail == 2)) done = 1;
      end
      chk("frame_done", done, 1'b1);
      chk("start_count", starts, v.exp_starts);
      chk("frame_count", frame_count, v.exp_fc);
      chk("err_framing", err_framing, v.exp_err);
      if (v.exp_starts > 0) chk("words_out", j, NO);
      chk("busy_idle", busy, 1'b0);
      chk("in_ready_idle", in_ready, 1'b1);
   endtask

   initial begin
      int n, st;
`ifdef RNN_TIMEOUT_EN
      vec_t tv;
`endif
      //         feat_base     last vad           gain_base     lat stl bp nc st err fc
      vecs[0] = '{32'h0001_0000, 41, 32'h0000_C000, 32'h0000_0000, 10, 0, 0, 0, 1, 0, 16'd1};
      vecs[1] = '{32'h0002_0000, 41, 32'h1111_0000, 32'h0000_0100, 10, 1, 0, 0, 1, 0, 16'd2};
      vecs[2] = '{32'h0003_0000, 41, 32'hDEAD_BEEF, 32'hA000_0000,  4, 0, 1, 0, 1, 0, 16'd3};
      vecs[3] = '{32'h0004_0000, -1, 32'h0BAD_F00D, 32'h0000_0040,  6, 0, 0, 0, 1, 1, 16'd4};
      vecs[4] = '{32'h0005_0000, 10, 32'h0000_0000, 32'h0000_0000, 10, 0, 0, 0, 0, 1, 16'd0};
      vecs[5] = '{32'h0006_0000, 41, 32'h1234_5678, 32'h0000_0077,  3, 0, 0, 0, 1, 1, 16'd1};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      rnn_valid = 1'b0; rnn_vad = '0; rnn_gains = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_rnn_start", rnn_start, 1'b0);
      chk("rst_feature", rnn_feature == '0, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_frame_count", frame_count, 16'd0);
      chk("rst_err_framing", err_framing, 1'b0);
`ifdef RNN_TIMEOUT_EN
      chk("rst_err_timeout", err_timeout, 1'b0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1'b1);

      for (int t = 0; t < 4; t++) run_frame(vecs[t]);

      // Reset while the driver waits on a core that never completes.
      n = 0; st = -1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (rnn_start) begin st = c; rnn_valid = 1'b0; end
         if (n < NW && in_ready) begin
            in_valid = 1'b1; in_data = 32'h0009_0000 + 32'(n); in_last = (n == NW - 1); n++;
         end else begin
            in_valid = 1'b0; in_last = 1'b0;
         end
         if (st >= 0 && c == st + 5) break;
      end
      chk("wait_busy", busy, 1'b1);
      chk("wait_no_out", out_valid, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_in_ready", in_ready, 1'b0);
      chk("async_busy", busy, 1'b0);
      chk("async_frame_count", frame_count, 16'd0);
      chk("async_err_framing", err_framing, 1'b0);
      chk("async_feature", rnn_feature == '0, 1'b1);
      chk("async_rnn_start", rnn_start, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", in_ready, 1'b1);
      chk("rel_frame_count", frame_count, 16'd0);

      for (int t = 4; t < 6; t++) run_frame(vecs[t]);

`ifdef RNN_TIMEOUT_EN
      tv = '{32'h0007_0000, 41, 32'h5555_5555, 32'h0000_0099, 10, 0, 0, 1, 1, 1, 16'd1};
      run_frame(tv);
      chk("err_timeout", err_timeout, 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rnn_frame_driver.md
Name: rnn_frame_driver

Overview:
- Host-side initiator for the RNN inference core's start/valid interface.
- Collects one frame of INPUT_SIZE feature words from a ready/valid input stream and packs them into the wide feature bus.
- Issues a single-cycle start, waits for the core's completion, then snapshots vad and gains.
- Returns the snapshot as a ready/valid output stream of 1 + GAIN_SIZE words.

Parameters:
- FIXED, 32, width of one fixed-point word
- INPUT_SIZE, 42, feature words per frame
- GAIN_SIZE, 22, gain words per frame
- TIMEOUT_CYCLES, 65535, watchdog limit in the WAIT state (used only with RNN_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  feature word valid
- in_ready  out  1  driver accepts a feature word
- in_data  in  FIXED  feature word, index order 0..INPUT_SIZE-1
- in_last  in  1  marks the final feature word of a frame
- rnn_feature  out  INPUT_SIZE*FIXED  packed features to the core; word i at [(i+1)*FIXED-1 : i*FIXED]
- rnn_start  out  1  start pulse to the core
- rnn_valid  in  1  core completion level
- rnn_vad  in  FIXED  core vad result
- rnn_gains  in  GAIN_SIZE*FIXED  core gains, packed like rnn_feature
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts a result word
- out_data  out  FIXED  result word
- out_last  out  1  high on the final result word
- busy  out  1  high in any state other than LOAD with zero words loaded
- frame_count  out  16  completed frames, wraps at 65535 to 0
- err_framing  out  1  sticky framing error

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 (in_ready 0, rnn_start 0, rnn_feature 0, out_valid 0, out_data 0). State goes to LOAD. Word counter goes to 0.
- Reset mid-operation: any in-flight frame is abandoned and no start is issued. The core is not otherwise notified.
- LOAD state:
  - in_ready=1.
  - On in_valid&&in_ready, write word k into slot k and increment k.
  - When k=INPUT_SIZE-1 is accepted with in_last=1, go to START.
  - If in_last=1 arrives at k<INPUT_SIZE-1 (early last): drop the frame, set k=0, set err_framing, stay in LOAD.
  - If k=INPUT_SIZE-1 is accepted with in_last=0: set err_framing but still go to START. The length is authoritative.
- START state: rnn_start=1 for exactly one cycle, in_ready=0, then go to GUARD.
- GUARD state:
  - Lasts one cycle.
  - rnn_valid is ignored here, because the core's valid from the previous frame stays high until the core samples start.
  - Then go to WAIT.
- WAIT state:
  - On rnn_valid=1, capture rnn_vad and rnn_gains into the result buffer, increment frame_count, set output index j=0, go to DRAIN.
- rnn_feature stays stable from START until leaving WAIT. It is only rewritten during LOAD.
- DRAIN state:
  - out_valid=1.
  - out_data = vad when j=0, gains[j-1] for j=1..GAIN_SIZE.
  - out_last=1 when j=GAIN_SIZE.
  - On out_valid&&out_ready, increment j. After the handshake on the last word, go to LOAD with k=0.
  - out_data and out_last hold stable while out_ready=0.
- Latency:
  - Last input word accepted at edge N → rnn_start high during cycle N+1.
  - rnn_valid sampled at edge M → out_valid high in cycle M+1.
- Arithmetic: no arithmetic on data words; they are pass-through only. Counters are unsigned and wrap.

Optional Feature:
- Macro: RNN_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit cycle counter runs in WAIT.
  - If TIMEOUT_CYCLES cycles elapse without rnn_valid: set a sticky port err_timeout (out, 1, reset 0), and drain a result frame of 1+GAIN_SIZE all-zero words.
  - frame_count is not incremented for that frame.
- Without the macro: no counter and no err_timeout port. WAIT waits indefinitely.

Decomposition:
- Shared package holds:
  - localparams FIXED, INPUT_SIZE, GAIN_SIZE
  - state encoding: LOAD=0, START=1, GUARD=2, WAIT=3, DRAIN=4
  - counter width function clog2 used for k and j
- One natural sub-module, rnn_result_serializer: holds the result buffer, index j, and the out_* handshake.

Test Plan:
- Nominal frame:
  - Stimulus: 42 words 0x00010000+i with in_last on i=41; core model asserts rnn_valid 10 cycles after start, with vad=0x0000C000 and gains[i]=i.
  - Expected: rnn_feature word 5 = 0x00010005; exactly one rnn_start pulse; out stream 0x0000C000, 0, 1 … 21 with out_last on word 22; frame_count=1.
- Stale valid:
  - Stimulus: core model holds rnn_valid=1 from the previous frame until one cycle after start.
  - Expected: driver does not complete early; results come from the new frame.
- Backpressure:
  - Stimulus: toggle out_ready 1/0 every cycle.
  - Expected: all 23 words delivered in order; out_data stable while stalled; in_ready=0 throughout DRAIN.
- Framing errors:
  - Stimulus: in_last at i=10.
  - Expected: no start; err_framing=1; a following correct 42-word frame processes normally.
  - Stimulus: 42 words with no in_last.
  - Expected: start is issued; err_framing=1.
- Reset in WAIT:
  - Stimulus: assert rst_n=0 in the WAIT state.
  - Expected: outputs clear immediately without waiting for clk; after release in_ready=1 and frame_count=0.
- Timeout (RNN_TIMEOUT_EN defined, TIMEOUT_CYCLES=100):
  - Stimulus: core model never asserts rnn_valid.
  - Expected: err_timeout=1; 23 zero words drained; frame_count unchanged.
